axi_stripe_r: RTL and testbench
===============================

# axi_stripe_r

Read-data reassembly stage directly downstream of the address striper in the DDR striping path. The address striper splits each AXI read into per-channel fragments and pushes one sequence entry per fragment (last flag, channel id, beat length). This block buffers the per-channel read-data beats returned by the memory interconnect and replays them to the requester strictly in sequence-entry order. `rlast` is asserted only on the final beat of the final fragment, so the split is invisible to the master.

## Interface
Parameters (constants from `lynxTypes`):
- `N_DDR_CHAN`, `N_DDR_CHAN_BITS`: number of DDR channels, and its log2; from `lynxTypes`.
- `AXI_DATA_BITS`: data beat width; from `lynxTypes`.
- `STRIPE_RD_FIFO_DEPTH`, default 512: beats buffered per channel (power of two).

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset; asynchronous, active-low.
- `mux`  metaIntf.s  data `1+N_DDR_CHAN_BITS+8`: sequence entry `{ctl, id, len}`.
  - `ctl` = final fragment.
  - `id` = DDR channel.
  - `len` = beats-1.
- `s_axi_rdata`  in  AXI_DATA_BITS  beat from interconnect.
- `s_axi_rid`  in  AXI_ID_BITS  returning channel; low `N_DDR_CHAN_BITS` bits used.
- `s_axi_rresp`  in  2  response code.
- `s_axi_rlast`  in  1  end of fragment burst; ignored.
- `s_axi_rvalid` in, `s_axi_rready` out  1  handshake.
- `m_axi_rdata`  out  AXI_DATA_BITS  reassembled beat.
- `m_axi_rresp`  out  2  passed through per beat.
- `m_axi_rid`  out  AXI_ID_BITS  constant 0.
- `m_axi_rlast`  out  1  final beat of whole transfer.
- `m_axi_rvalid` out, `m_axi_rready` in  1  handshake.

## Operation
- Incoming beats:
  - Every incoming beat is written to `fifo[rid]`.
  - `s_axi_rready = ~full[s_axi_rid]`. A beat for a full FIFO stalls; beats for other channels behind it are held by the interconnect.
  - System sizing rule: `STRIPE_RD_FIFO_DEPTH` ≥ outstanding beats per channel, which guarantees no deadlock.
- FSM `ST_IDLE` / `ST_STREAM`.
- `ST_IDLE`:
  - `mux.ready=1`.
  - On `mux.valid`: latch `id_C`, `len_C`, `ctl_C`; clear `cnt_C`; go to `ST_STREAM`.
- `ST_STREAM`:
  - `m_axi_rvalid = ~empty[id_C]`; data and resp come from the head of `fifo[id_C]`.
  - `m_axi_rlast = ctl_C & (cnt_C==len_C)`.
  - Each output handshake pops `fifo[id_C]` and increments `cnt_C` (8-bit; `len` ≤ 255, no wrap).
  - On the handshake where `cnt_C==len_C`, the fragment is complete:
    - `mux.ready=1` in that same cycle.
    - If `mux.valid`: load the next entry and stay in `ST_STREAM` (zero-bubble switch).
    - Otherwise go to `ST_IDLE`.
- Other channels' FIFOs keep filling while one channel is drained; beats of different channels never mix in the output.
- `rresp` is not merged; an error beat is forwarded unchanged.
- Simultaneous write and pop on the same FIFO is legal; occupancy stays unchanged.

## Timing
- Reset (`aresetn` low, asynchronous): FSM to `ST_IDLE`; all counters zero; all FIFOs empty.
  - Outputs: `m_axi_rvalid=0`, `m_axi_rlast=0`, `m_axi_rdata=0`, `m_axi_rresp=0`, `s_axi_rready=0`, `mux.ready=0`.
  - After release: `s_axi_rready=1` from the first clock edge; `mux.ready=1` from the first clock edge.
- Reset mid-transfer discards all buffered beats and the current entry.
- Beat latency input→output: 1 cycle minimum. Beat written at edge n is presented after edge n+1 if its fragment is current.
- Fragment entry latency: entry accepted at edge n → first beat can be presented at cycle n+1.
- Throughput: 1 beat/cycle sustained, including across fragment boundaries.
- `full` and `empty` are registered flags. The `s_axi_rready`→`s_axi_rid` path is a registered-flag mux only.
- AXI rule: once `m_axi_rvalid` is high, it and the output data stay stable until `m_axi_rready`.

## Structure
- `lynxTypes` gains `STRIPE_RD_FIFO_DEPTH` and the typedef `stripe_seq_t` (`ctl`, `id`, `len`), shared with the address striper.
- Sub-module `axi_stripe_r_fifo`:
  - Per-channel first-word-fall-through FIFO, `AXI_DATA_BITS+2` wide, async active-low reset.
  - Exposes `full` and `empty`.
  - Instantiated `N_DDR_CHAN` times in a generate loop.
- Top level holds the FSM, the counter and the write/read steering muxes.

## Test plan
- Single fragment, 4 beats:
  - Stimulus: `mux={1,0,3}`, 4 beats on `rid=0` with data 0..3.
  - Response: 4 output beats 0..3; `rlast` on beat 3 only.
- Split transfer, 64-beat fragments, channel 1's data arrives first:
  - Stimulus: entries `{0,0,63}` then `{1,1,35}`; 36 beats on `rid=1` arrive before 64 beats on `rid=0`.
  - Response: the 64 channel-0 beats, then the 36 channel-1 beats; `rlast` only on beat 100; no `rlast` at beat 64.
- Back-to-back fragments:
  - Stimulus: two entries queued, FIFOs pre-filled, `m_axi_rready=1` held.
  - Response: `m_axi_rvalid` continuous across the boundary; no idle cycle.
- Output backpressure:
  - Stimulus: `m_axi_rready` pseudo-random at 50% during a 4-fragment transfer of 200 beats.
  - Response: all 200 beats in order, no duplicates; data stable while stalled.
- FIFO full:
  - Stimulus: 512 beats on `rid=1` with no channel-1 entry.
  - Response: `s_axi_rready=0` while `rid=1` is presented; switching to `rid=0` gives `s_axi_rready=1`; an error `rresp=2` on one beat appears unchanged at the output.
- Reset mid-burst:
  - Stimulus: `aresetn` driven low at output beat 10 of 64.
  - Response: all outputs 0 immediately; after release a fresh `{1,2,7}` transfer completes correctly with no stale data.

Source files
------------

// File: rtl/axi_stripe_r_pkg.sv
// Shared types and sizing for the DDR striping read path: channel count,
// data width, per-channel read buffering and the sequence entry format.
package axi_stripe_r_pkg;

    localparam int N_DDR_CHAN           = 4;
    localparam int N_DDR_CHAN_BITS      = 2;
    localparam int AXI_DATA_BITS        = 64;
    localparam int AXI_ID_BITS          = 6;
    localparam int STRIPE_RD_FIFO_DEPTH = 512;
    localparam int SEQ_BITS             = 1 + N_DDR_CHAN_BITS + 8;

    // One entry per fragment pushed by the address striper.
    typedef struct packed {
        logic                       ctl;
        logic [N_DDR_CHAN_BITS-1:0] id;
        logic [7:0]                 len;
    } stripe_seq_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } stripe_state_e;

    function automatic stripe_seq_t seq_unpack(input logic [SEQ_BITS-1:0] raw);
        return stripe_seq_t'(raw);
    endfunction

endpackage

// File: rtl/axi_stripe_r_fifo.sv
// First-word-fall-through per-channel beat buffer. The head sits in an output
// register loaded by a synchronous memory read, so full/empty are registered.
module axi_stripe_r_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 512
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      occ_q, occ_d, mem_cnt_s;
    logic             out_valid_q, out_valid_d, full_q, full_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             wr_ok_s, pop_s, load_s;

    // Pointer, occupancy and head-register next state; occupancy includes the head.
    always_comb begin
        wr_ok_s     = wr_en & ~full_q;
        pop_s       = rd_en & out_valid_q;
        mem_cnt_s   = occ_q - (AW+1)'(out_valid_q);
        load_s      = (mem_cnt_s != '0) & (~out_valid_q | pop_s);
        wr_ptr_d    = wr_ptr_q + AW'(wr_ok_s);
        rd_ptr_d    = rd_ptr_q + AW'(load_s);
        occ_d       = occ_q + (AW+1)'(wr_ok_s) - (AW+1)'(pop_s);
        full_d      = (occ_d == (AW+1)'(DEPTH));
        out_data_d  = load_s ? mem[rd_ptr_q] : out_data_q;
        if (load_s) begin
            out_valid_d = 1'b1;
        end else if (pop_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Storage array carries no reset so it can map onto block RAM.
    always_ff @(posedge aclk) begin
        if (wr_ok_s) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Control and head registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            full_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign rd_data = out_data_q;
    assign full    = full_q;
    assign empty   = ~out_valid_q;

endmodule

// File: rtl/axi_stripe_r.sv
// Read-data reassembly: buffers per-channel read beats and replays them to the
// master in sequence-entry order, with rlast only on the final fragment's last beat.
module axi_stripe_r
    import axi_stripe_r_pkg::*;
#(
    parameter int FIFO_DEPTH = STRIPE_RD_FIFO_DEPTH
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     mux_valid,
    output logic                     mux_ready,
    input  logic [SEQ_BITS-1:0]      mux_data,
    input  logic [AXI_DATA_BITS-1:0] s_axi_rdata,
    input  logic [AXI_ID_BITS-1:0]   s_axi_rid,
    input  logic [1:0]               s_axi_rresp,
    input  logic                     s_axi_rlast,
    input  logic                     s_axi_rvalid,
    output logic                     s_axi_rready,
    output logic [AXI_DATA_BITS-1:0] m_axi_rdata,
    output logic [1:0]               m_axi_rresp,
    output logic [AXI_ID_BITS-1:0]   m_axi_rid,
    output logic                     m_axi_rlast,
    output logic                     m_axi_rvalid,
    input  logic                     m_axi_rready
);

    localparam int FIFO_W = AXI_DATA_BITS + 2;

    logic [N_DDR_CHAN-1:0]      wr_en_s, rd_en_s, full_s, empty_s;
    logic [FIFO_W-1:0]          head_s [N_DDR_CHAN];
    logic [FIFO_W-1:0]          head_sel_s;
    logic [N_DDR_CHAN_BITS-1:0] rid_ch_s;
    stripe_seq_t                seq_s;
    stripe_state_e              state_q, state_d;
    logic                       ctl_q, ctl_d;
    logic [N_DDR_CHAN_BITS-1:0] id_q, id_d;
    logic [7:0]                 len_q, len_d, cnt_q, cnt_d;
    logic                       en_q, en_d;
    logic                       out_valid_s, out_hs_s, last_beat_s, frag_done_s;
    logic                       unused_ok_s;

    // Fragment bursts are delimited by sequence entries, so the returning rlast is not needed.
    assign unused_ok_s = ^{s_axi_rlast, s_axi_rid[AXI_ID_BITS-1:N_DDR_CHAN_BITS]};

    for (genvar g = 0; g < N_DDR_CHAN; g++) begin : g_chan
        localparam logic [N_DDR_CHAN_BITS-1:0] CH = N_DDR_CHAN_BITS'(g);
        assign wr_en_s[g] = s_axi_rvalid & s_axi_rready & (rid_ch_s == CH);
        assign rd_en_s[g] = out_hs_s & (id_q == CH);

        axi_stripe_r_fifo #(
            .WIDTH (FIFO_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .aclk    (aclk),
            .aresetn (aresetn),
            .wr_en   (wr_en_s[g]),
            .wr_data ({s_axi_rdata, s_axi_rresp}),
            .rd_en   (rd_en_s[g]),
            .rd_data (head_s[g]),
            .full    (full_s[g]),
            .empty   (empty_s[g])
        );
    end

    // Steering, handshakes and output muxing; data is forced to zero when not valid.
    always_comb begin
        seq_s        = seq_unpack(mux_data);
        rid_ch_s     = s_axi_rid[N_DDR_CHAN_BITS-1:0];
        s_axi_rready = en_q & ~full_s[rid_ch_s];
        head_sel_s   = head_s[id_q];
        out_valid_s  = (state_q == ST_STREAM) & ~empty_s[id_q];
        out_hs_s     = out_valid_s & m_axi_rready;
        last_beat_s  = (cnt_q == len_q);
        frag_done_s  = out_hs_s & last_beat_s;
        if (state_q == ST_IDLE) begin
            mux_ready = en_q;
        end else begin
            mux_ready = en_q & frag_done_s;
        end
        m_axi_rvalid = out_valid_s;
        m_axi_rlast  = out_valid_s & ctl_q & last_beat_s;
        m_axi_rdata  = out_valid_s ? head_sel_s[FIFO_W-1:2] : '0;
        m_axi_rresp  = out_valid_s ? head_sel_s[1:0] : 2'b00;
        m_axi_rid    = '0;
    end

    // Sequencer next state; a completing fragment may load the next entry in the same cycle.
    always_comb begin
        state_d = state_q;
        ctl_d   = ctl_q;
        id_d    = id_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        en_d    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (mux_valid & mux_ready) begin
                    ctl_d   = seq_s.ctl;
                    id_d    = seq_s.id;
                    len_d   = seq_s.len;
                    cnt_d   = 8'd0;
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (frag_done_s) begin
                    if (mux_valid) begin
                        ctl_d   = seq_s.ctl;
                        id_d    = seq_s.id;
                        len_d   = seq_s.len;
                        cnt_d   = 8'd0;
                        state_d = ST_STREAM;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (out_hs_s) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers; en_q holds both ready outputs low until the first edge after reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            ctl_q   <= 1'b0;
            id_q    <= '0;
            len_q   <= 8'd0;
            cnt_q   <= 8'd0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
            id_q    <= id_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
        end
    end

endmodule

// File: tb/tb_axi_stripe_r.sv
// Directed bench for axi_stripe_r: reset values, ordered reassembly, zero-bubble
// fragment switching, output backpressure, full-FIFO stall and mid-burst reset.
module tb_axi_stripe_r;
    import axi_stripe_r_pkg::*;

    localparam int DW    = AXI_DATA_BITS;
    localparam int LIMIT = 5000;

    logic                   aclk = 1'b0;
    logic                   aresetn = 1'b0;
    logic                   mux_valid = 1'b0;
    logic                   mux_ready;
    logic [SEQ_BITS-1:0]    mux_data = '0;
    logic [DW-1:0]          s_axi_rdata = '0;
    logic [AXI_ID_BITS-1:0] s_axi_rid = '0;
    logic [1:0]             s_axi_rresp = 2'b00;
    logic                   s_axi_rlast = 1'b0;
    logic                   s_axi_rvalid = 1'b0;
    logic                   s_axi_rready;
    logic [DW-1:0]          m_axi_rdata;
    logic [1:0]             m_axi_rresp;
    logic [AXI_ID_BITS-1:0] m_axi_rid;
    logic                   m_axi_rlast;
    logic                   m_axi_rvalid;
    logic                   m_axi_rready = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;
    int drv_timeouts = 0;

    logic [DW-1:0] rx_data [$];
    logic [1:0]    rx_resp [$];
    logic          rx_last [$];
    int            rx_unstable;
    int            rx_gaps;
    bit            rx_timeout;

    always #5 aclk = ~aclk;

    axi_stripe_r dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .mux_valid    (mux_valid),
        .mux_ready    (mux_ready),
        .mux_data     (mux_data),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rid    (s_axi_rid),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rlast  (s_axi_rlast),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rid    (m_axi_rid),
        .m_axi_rlast  (m_axi_rlast),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready)
    );

    function automatic logic [DW-1:0] mk(input int ch, input int idx);
        return (DW'(ch) << 32) | DW'(idx);
    endfunction

    // Drives n beats on channel ch; err_idx marks the one beat returned with SLVERR.
    task automatic send_beats(input int ch, input int base, input int n, input int err_idx);
        int sent;
        int guard;
        sent  = 0;
        guard = 0;
        while (sent < n && guard < LIMIT) begin
            @(negedge aclk);
            s_axi_rvalid = 1'b1;
            s_axi_rid    = AXI_ID_BITS'(ch);
            s_axi_rdata  = mk(ch, base + sent);
            s_axi_rresp  = (sent == err_idx) ? 2'b10 : 2'b00;
            s_axi_rlast  = (sent == n - 1);
            #1;
            if (s_axi_rready) sent++;
            guard++;
        end
        if (sent < n) drv_timeouts++;
        @(negedge aclk);
        s_axi_rvalid = 1'b0;
        s_axi_rlast  = 1'b0;
    endtask

    // Presents one entry until accepted and leaves mux_valid high for a following call.
    task automatic send_entry(input bit ctl, input int id, input int len);
        int guard;
        bit done;
        guard = 0;
        done  = 1'b0;
        while (!done && guard < LIMIT) begin
            @(negedge aclk);
            mux_valid = 1'b1;
            mux_data  = {ctl, N_DDR_CHAN_BITS'(id), 8'(len)};
            #1;
            if (mux_ready) done = 1'b1;
            guard++;
        end
        if (!done) drv_timeouts++;
    endtask

    task automatic end_entries();
        @(negedge aclk);
        mux_valid = 1'b0;
    endtask

    // Collects n output beats, tracking stall stability and valid gaps.
    task automatic recv_beats(input int n, input bit rnd);
        int got;
        int guard;
        bit started;
        bit holding;
        logic [DW-1:0] hold_d;
        got = 0;
        guard = 0;
        started = 1'b0;
        holding = 1'b0;
        hold_d = '0;
        rx_data.delete();
        rx_resp.delete();
        rx_last.delete();
        rx_unstable = 0;
        rx_gaps = 0;
        while (got < n && guard < LIMIT) begin
            @(negedge aclk);
            m_axi_rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (m_axi_rvalid) begin
                started = 1'b1;
                if (holding && m_axi_rdata !== hold_d) rx_unstable++;
                if (m_axi_rready) begin
                    rx_data.push_back(m_axi_rdata);
                    rx_resp.push_back(m_axi_rresp);
                    rx_last.push_back(m_axi_rlast);
                    got++;
                    holding = 1'b0;
                end else begin
                    holding = 1'b1;
                    hold_d  = m_axi_rdata;
                end
            end else begin
                if (holding) rx_unstable++;
                if (started) rx_gaps++;
                holding = 1'b0;
            end
            guard++;
        end
        rx_timeout = (got < n);
        @(negedge aclk);
        m_axi_rready = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        #1;
        tests_run++;
        if ({m_axi_rvalid, m_axi_rlast, m_axi_rresp, s_axi_rready, mux_ready} !== 6'b0 ||
            m_axi_rdata !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b l=%b d=%h r=%b srdy=%b mrdy=%b, want all 0",
                     m_axi_rvalid, m_axi_rlast, m_axi_rdata, m_axi_rresp, s_axi_rready, mux_ready);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        tests_run++;
        if (s_axi_rready !== 1'b0 || mux_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_pre_edge: got srdy=%b mrdy=%b, want 0 0", s_axi_rready, mux_ready);
        end
        @(negedge aclk);
        #1;
        tests_run++;
        if (s_axi_rready !== 1'b1 || mux_ready !== 1'b1 || m_axi_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_post_edge: got srdy=%b mrdy=%b v=%b, want 1 1 0",
                     s_axi_rready, mux_ready, m_axi_rvalid);
        end
    endtask

    task automatic test_single();
        send_beats(0, 0, 4, -1);
        fork
            begin send_entry(1'b1, 0, 3); end_entries(); end
            recv_beats(4, 1'b0);
        join
        tests_run++;
        if (rx_timeout || drv_timeouts != 0) begin
            tests_failed++;
            $display("FAIL single_timeout: got %0d beats, want 4", rx_data.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < rx_data.size()) begin
                tests_run++;
                if (rx_data[i] !== mk(0, i) || rx_last[i] !== (i == 3)) begin
                    tests_failed++;
                    $display("FAIL single beat %0d: got d=%h last=%b, want d=%h last=%b",
                             i, rx_data[i], rx_last[i], mk(0, i), (i == 3));
                end
            end
        end
        tests_run++;
        if (m_axi_rid !== '0) begin
            tests_failed++;
            $display("FAIL single_rid: got %h, want 0", m_axi_rid);
        end
    endtask

    task automatic test_split();
        fork
            begin send_entry(1'b0, 0, 63); send_entry(1'b1, 1, 35); end_entries(); end
            begin send_beats(1, 0, 36, -1); send_beats(0, 0, 64, -1); end
            recv_beats(100, 1'b0);
        join
        tests_run++;
        if (rx_timeout || drv_timeouts != 0) begin
            tests_failed++;
            $display("FAIL split_timeout: got %0d beats, want 100", rx_data.size());
        end
        for (int i = 0; i < 100; i++) begin
            if (i < rx_data.size()) begin
                tests_run++;
                if (rx_data[i] !== ((i < 64) ? mk(0, i) : mk(1, i - 64)) || rx_last[i] !== (i == 99)) begin
                    tests_failed++;
                    $display("FAIL split beat %0d: got d=%h last=%b, want d=%h last=%b", i,
                             rx_data[i], rx_last[i], (i < 64) ? mk(0, i) : mk(1, i - 64), (i == 99));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        send_beats(2, 0, 8, -1);
        send_beats(3, 0, 8, -1);
        fork
            begin send_entry(1'b0, 2, 7); send_entry(1'b1, 3, 7); end_entries(); end
            recv_beats(16, 1'b0);
        join
        tests_run++;
        if (rx_timeout || drv_timeouts != 0 || rx_gaps != 0) begin
            tests_failed++;
            $display("FAIL b2b_continuity: got %0d beats, %0d gap cycles, want 16 beats 0 gaps",
                     rx_data.size(), rx_gaps);
        end
        for (int i = 0; i < 16; i++) begin
            if (i < rx_data.size()) begin
                tests_run++;
                if (rx_data[i] !== ((i < 8) ? mk(2, i) : mk(3, i - 8)) || rx_last[i] !== (i == 15)) begin
                    tests_failed++;
                    $display("FAIL b2b beat %0d: got d=%h last=%b, want d=%h last=%b", i,
                             rx_data[i], rx_last[i], (i < 8) ? mk(2, i) : mk(3, i - 8), (i == 15));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int flen [4];
        logic [DW-1:0] exp_q [$];
        flen = '{50, 60, 40, 50};
        for (int c = 0; c < 4; c++)
            for (int b = 0; b < flen[c]; b++) exp_q.push_back(mk(c, b));
        fork
            begin
                for (int c = 0; c < 4; c++) send_entry(c == 3, c, flen[c] - 1);
                end_entries();
            end
            begin
                for (int c = 3; c >= 0; c--) send_beats(c, 0, flen[c], -1);
            end
            recv_beats(200, 1'b1);
        join
        tests_run++;
        if (rx_timeout || drv_timeouts != 0 || rx_unstable != 0) begin
            tests_failed++;
            $display("FAIL bp_stall: got %0d beats, %0d unstable stalls, want 200 beats 0 unstable",
                     rx_data.size(), rx_unstable);
        end
        for (int i = 0; i < 200; i++) begin
            if (i < rx_data.size()) begin
                tests_run++;
                if (rx_data[i] !== exp_q[i] || rx_last[i] !== (i == 199)) begin
                    tests_failed++;
                    $display("FAIL bp beat %0d: got d=%h last=%b, want d=%h last=%b",
                             i, rx_data[i], rx_last[i], exp_q[i], (i == 199));
                end
            end
        end
    endtask

    task automatic test_fifo_full();
        send_beats(1, 0, 512, 5);
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            s_axi_rvalid = 1'b1;
            s_axi_rid    = AXI_ID_BITS'(1);
            s_axi_rdata  = mk(1, 999);
            #1;
            tests_run++;
            if (s_axi_rready !== 1'b0) begin
                tests_failed++;
                $display("FAIL full_stall cycle %0d: got srdy=%b, want 0", k, s_axi_rready);
            end
        end
        @(negedge aclk);
        s_axi_rvalid = 1'b0;
        s_axi_rid    = '0;
        #1;
        tests_run++;
        if (s_axi_rready !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_other_chan: got srdy=%b, want 1", s_axi_rready);
        end
        fork
            begin send_entry(1'b0, 1, 255); send_entry(1'b1, 1, 255); end_entries(); end
            recv_beats(512, 1'b0);
        join
        tests_run++;
        if (rx_timeout || drv_timeouts != 0) begin
            tests_failed++;
            $display("FAIL full_timeout: got %0d beats, want 512", rx_data.size());
        end
        for (int i = 0; i < 512; i++) begin
            if (i < rx_data.size()) begin
                tests_run++;
                if (rx_data[i] !== mk(1, i) || rx_resp[i] !== ((i == 5) ? 2'b10 : 2'b00) ||
                    rx_last[i] !== (i == 511)) begin
                    tests_failed++;
                    $display("FAIL full beat %0d: got d=%h resp=%b last=%b, want d=%h resp=%b last=%b",
                             i, rx_data[i], rx_resp[i], rx_last[i], mk(1, i),
                             (i == 5) ? 2'b10 : 2'b00, (i == 511));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        send_beats(2, 900, 4, -1);
        send_beats(0, 0, 64, -1);
        fork
            begin send_entry(1'b1, 0, 63); end_entries(); end
            recv_beats(10, 1'b0);
        join
        tests_run++;
        if (rx_timeout || m_axi_rvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_pre: got %0d beats v=%b, want 10 beats v=1", rx_data.size(), m_axi_rvalid);
        end
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        tests_run++;
        if ({m_axi_rvalid, m_axi_rlast, m_axi_rresp, s_axi_rready, mux_ready} !== 6'b0 ||
            m_axi_rdata !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got v=%b l=%b d=%h r=%b srdy=%b mrdy=%b, want all 0",
                     m_axi_rvalid, m_axi_rlast, m_axi_rdata, m_axi_rresp, s_axi_rready, mux_ready);
        end
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        send_beats(2, 100, 8, -1);
        fork
            begin send_entry(1'b1, 2, 7); end_entries(); end
            recv_beats(8, 1'b0);
        join
        tests_run++;
        if (rx_timeout || drv_timeouts != 0) begin
            tests_failed++;
            $display("FAIL mid_post_timeout: got %0d beats, want 8", rx_data.size());
        end
        for (int i = 0; i < 8; i++) begin
            if (i < rx_data.size()) begin
                tests_run++;
                if (rx_data[i] !== mk(2, 100 + i) || rx_last[i] !== (i == 7)) begin
                    tests_failed++;
                    $display("FAIL mid_post beat %0d: got d=%h last=%b, want d=%h last=%b",
                             i, rx_data[i], rx_last[i], mk(2, 100 + i), (i == 7));
                end
            end
        end
        repeat (3) @(negedge aclk);
        #1;
        tests_run++;
        if (m_axi_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_no_stale: got v=%b after transfer, want 0", m_axi_rvalid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_split();
        test_back_to_back();
        test_backpressure();
        test_fifo_full();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
